// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite constants, AWPROT bit positions and the address-entry record
// used by the write-address buffer and its neighbours.
package axi_lite_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int AXI_PROT_PRIV   = 0;
  localparam int AXI_PROT_NONSEC = 1;
  localparam int AXI_PROT_INSTR  = 2;

  localparam int AXI_ADDR_WIDTH = 32;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [2:0]                prot;
    logic                      err;
  } aw_entry_t;

  function automatic logic axi_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/axi_lite_aw_buffer_if.sv
// AW channel from the interconnect plus the head-of-queue port towards the write engine.
interface axi_lite_aw_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);

  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;

  logic                    o_valid;
  logic                    i_ready;
  logic [ADDR_WIDTH-1:0]   o_addr;
  logic [2:0]              o_prot;
  logic                    o_err;
  logic [$clog2(DEPTH):0]  o_count;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, i_ready,
    output AWREADY, o_valid, o_addr, o_prot, o_err, o_count
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, i_ready,
    input  AWREADY, o_valid, o_addr, o_prot, o_err, o_count
  );

endinterface

// File: rtl/axi_lite_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is zero whenever the FIFO is empty.
// Callers must not push when full nor pop when empty.
module axi_lite_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  // NOTE: the storage array is deliberately left out of reset; stale words are never
  // visible because the head output is masked to zero while the FIFO is empty.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign count_next = count_q + CNT_W'(push) - CNT_W'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_next;
    end
  end

  assign count   = count_q;
  assign rd_data = (count_q != '0) ? mem[rd_ptr] : '0;

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge ACLK) disable iff (ARESET)
    push |-> count_q != CNT_W'(DEPTH));
  a_no_pop_empty: assert property (@(posedge ACLK) disable iff (ARESET)
    pop |-> count_q != '0);
  a_count_bound: assert property (@(posedge ACLK) disable iff (ARESET)
    count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: rtl/axi_lite_aw_buffer.sv
// AXI4-Lite write-address slave: accepts AW beats, tags decode/alignment errors and
// queues them for the write engine so address acceptance runs ahead of completion.
module axi_lite_aw_buffer
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH       = 4,
  parameter bit                    ALIGN_CHECK = 1'b1,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE   = '0,
  parameter longint unsigned       ADDR_SIZE   = 4096
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  axi_lite_aw_buffer_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Range arithmetic carries one extra bit so base+size near the top of the map cannot wrap.
  localparam logic [ADDR_WIDTH:0] BASE_EXT = {1'b0, ADDR_BASE};
  localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH+1)'(ADDR_SIZE);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            prot;
    logic                  err;
  } entry_t;

  logic             awready_q;
  logic             push;
  logic             pop;
  logic             not_empty;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  entry_t           wr_entry;
  entry_t           rd_entry;

  logic [ADDR_WIDTH:0] addr_ext;
  logic [ADDR_WIDTH:0] offset;
  logic                align_err;
  logic                range_err;

  assign addr_ext  = {1'b0, bus.AWADDR};
  assign offset    = addr_ext - BASE_EXT;
  assign align_err = ALIGN_CHECK && axi_misaligned(bus.AWADDR[1:0]);
  assign range_err = (SIZE_EXT != '0) && ((addr_ext < BASE_EXT) || (offset >= SIZE_EXT));

  assign wr_entry = '{addr: bus.AWADDR, prot: bus.AWPROT, err: align_err | range_err};

  assign not_empty = (count != '0);
  assign push      = bus.AWVALID & awready_q;
  assign pop       = not_empty & bus.i_ready;

  axi_lite_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .push       (push),
    .wr_data    (wr_entry),
    .pop        (pop),
    .rd_data    (rd_entry),
    .count      (count),
    .count_next (count_next)
  );

  // Ready looks at next-cycle occupancy only, never at AWVALID, so it stays a clean flop.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) awready_q <= 1'b0;
    else        awready_q <= (count_next < CNT_W'(DEPTH));
  end

  assign bus.AWREADY = awready_q;
  assign bus.o_valid = not_empty;
  assign bus.o_addr  = rd_entry.addr;
  assign bus.o_prot  = rd_entry.prot;
  assign bus.o_err   = rd_entry.err;
  assign bus.o_count = count;

endmodule
